// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the M stage: one outstanding load/store, response LATENCY cycles after accept.
// Optional misaligned-access trapping is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_data;
  logic        r_err;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic              w_accept;
  logic              w_mis;
  logic [31:0]       w_cap_data;
  logic              w_unused_addr;

  assign w_idx    = req_addr[ADDR_W+1:2];
  assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign w_mis = |req_addr[1:0];
`else
  assign w_mis = 1'b0;
`endif

  // Upper address bits wrap modulo DEPTH; low byte-lane bits only matter for the align check.
  assign w_unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

  // Load data is the array value before any same-edge store.
  assign w_cap_data = w_mis  ? 32'd0 :
                      req_we ? req_wdata : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (rst_n && w_accept && req_we && !w_mis) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_data       <= 32'd0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_data <= w_cap_data;
            r_err  <= w_mis;
            if (LATENCY == 1) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_cap_data;
              r_resp_err   <= w_mis;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_data;
            r_resp_err   <= r_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  // Drops in the RESP cycle so the stalled stages advance on that edge.
  assign busy       = req_valid & ~r_resp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=3 instance driven from a vector table,
// plus hand sequences for reset-during-wait, back-to-back requests and a LATENCY=1 instance.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        v1_req_valid = 1'b0, v1_req_we = 1'b0;
  logic [31:0] v1_req_addr = '0, v1_req_wdata = '0;
  logic        v1_req_ready, v1_resp_valid, v1_resp_err, v1_busy;
  logic [31:0] v1_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v1_req_valid), .req_ready(v1_req_ready), .req_we(v1_req_we),
    .req_addr(v1_req_addr), .req_wdata(v1_req_wdata),
    .resp_valid(v1_resp_valid), .resp_rdata(v1_resp_rdata), .resp_err(v1_resp_err),
    .busy(v1_busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // One complete transfer on the LATENCY=3 instance, starting from an IDLE cycle.
  task automatic xfer(input string nm, input logic we, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    logic got;
    @(posedge clk); #1;
    chk({nm, " ready_idle"}, {31'd0, req_ready}, 32'd1);
    chk({nm, " no_resp_idle"}, {31'd0, resp_valid}, 32'd0);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    #1;
    chk({nm, " busy_req"}, {31'd0, busy}, 32'd1);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid) got = 1'b1;
    end
    rd = resp_rdata;
    er = resp_err;
    chk({nm, " busy_resp"}, {31'd0, busy}, 32'd0);
    chk({nm, " ready_resp"}, {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
  endtask

  // One transfer on the LATENCY=1 instance, starting from an IDLE cycle.
  task automatic xfer1(input string nm, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp);
    @(posedge clk); #1;
    chk({nm, " ready_idle"}, {31'd0, v1_req_ready}, 32'd1);
    v1_req_we = we; v1_req_addr = a; v1_req_wdata = d; v1_req_valid = 1'b1;
    @(posedge clk); #1;
    chk({nm, " valid_n1"}, {31'd0, v1_resp_valid}, 32'd1);
    chk({nm, " rdata"}, v1_resp_rdata, exp);
    chk({nm, " busy_resp"}, {31'd0, v1_busy}, 32'd0);
    v1_req_valid = 1'b0;
    @(posedge clk); #1;
    chk({nm, " pulse_end"}, {31'd0, v1_resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] exp_20;
    int          lowcnt, edges, resps, e1, e2;
    logic        saw_resp;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_1004, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0004, 32'h0,         32'h5A5A_5A5A, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[5] = '{1'b0, 32'hFFFF_F008, 32'h0,         32'h1234_5678, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
`ifdef DATA_MEM_ALIGN_CHECK_EN
    tbl[7] = '{1'b1, 32'h0000_0022, 32'h1111_1111, 32'h0,         1'b1};
    tbl[8] = '{1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 1'b0};
`else
    tbl[7] = '{1'b1, 32'h0000_0022, 32'h1111_1111, 32'h1111_1111, 1'b0};
    tbl[8] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111, 1'b0};
`endif
    tbl[9] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    exp_20 = tbl[8].exp_rdata;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst err", {31'd0, resp_err}, 32'd0);
    chk("rst1 ready", {31'd0, v1_req_ready}, 32'd1);
    chk("rst1 rdata", v1_resp_rdata, 32'd0);

    // Table-driven transfers on LATENCY=3
    for (int i = 0; i < 10; i++) begin
      xfer($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
    end

    // Reset during WAIT of a load drops the access
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h30; req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst ready", {31'd0, req_ready}, 32'd1);
    chk("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    chk("midrst no_resp", {31'd0, saw_resp}, 32'd0);
    chk("midrst rdata_cleared", resp_rdata, 32'd0);
    xfer("postrst", 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("postrst latency", 32'(lat), 32'd3);
    chk("postrst rdata", rd, exp_20);

    // Back-to-back: req_valid held through RESP with a new load payload
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hA5A5_0001; req_valid = 1'b1;
    lowcnt = 0; edges = 0; resps = 0; e1 = 0; e2 = 0; rd = '0;
    for (int i = 0; i < 30 && resps < 2; i++) begin
      @(posedge clk); #1;
      edges++;
      if (!busy) lowcnt++;
      if (resp_valid) begin
        resps++;
        if (resps == 1) begin
          e1 = edges;
          chk("b2b store rdata", resp_rdata, 32'hA5A5_0001);
          req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        end else begin
          e2 = edges;
          rd = resp_rdata;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b resp_count", 32'(resps), 32'd2);
    chk("b2b first_lat", 32'(e1), 32'd3);
    chk("b2b second_gap", 32'(e2 - e1), 32'd4);
    chk("b2b load rdata", rd, 32'hDEAD_BEEF);
    chk("b2b busy_low_cycles", 32'(lowcnt), 32'd2);
    xfer("b2b readback", 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk("b2b readback rdata", rd, 32'hA5A5_0001);

    // LATENCY=1 instance
    xfer1("lat1 st4", 1'b1, 32'h4, 32'h0000_0077, 32'h0000_0077);
    xfer1("lat1 st8", 1'b1, 32'h8, 32'h0000_0099, 32'h0000_0099);
    xfer1("lat1 ld4", 1'b0, 32'h4, 32'h0,         32'h0000_0077);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
